// File: rtl/rv_retire_trace_buffer.sv
// Retire trace buffer: captures one record (pc, instr, alu, wdata) per retired
// instruction into a circular buffer, then drains it oldest-first as a
// word-serial valid/ready stream.
//
// Readout handshake: a word transfers on any cycle where rd_valid && rd_ready.
// rd_valid stays high for the whole drain. While rd_valid && !rd_ready, rd_data
// and rd_word_idx hold. rd_valid never drops before the rd_last beat.
module rv_retire_trace_buffer #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            arm,
    input  logic            mode,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [CW-1:0]   post_count,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_wdata,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [XLEN-1:0] rd_data,
    output logic [1:0]      rd_word_idx,
    output logic            rd_last,
    output logic [2:0]      state,
    output logic [CW-1:0]   count,
    output logic            triggered,
    output logic            overflow,
    output logic [XLEN-1:0] debug_output
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_q, post_d;
    logic [CW-1:0]   post_cfg_q, post_cfg_d;
    logic [1:0]      word_q, word_d;
    logic            rd_valid_q, rd_valid_d;
    logic            triggered_q, triggered_d;
    logic            overflow_q, overflow_d;
    logic            mode_q, mode_d;
    logic [XLEN-1:0] trig_pc_q, trig_pc_d;
    logic [XLEN-1:0] debug_q, debug_d;
    logic            wr_en;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] alu_mem_q   [DEPTH];
    logic [XLEN-1:0] wdata_mem_q [DEPTH];

    // Next-state logic: arm handling, capture, trigger/post window and drain.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q;
        post_d      = post_q;
        post_cfg_d  = post_cfg_q;
        word_d      = word_q;
        rd_valid_d  = rd_valid_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        mode_d      = mode_q;
        trig_pc_d   = trig_pc_q;
        debug_d     = debug_q;
        wr_en       = 1'b0;

        if (state_q == S_DRAIN) begin
            // arm is ignored while draining; late retires are dropped.
            if (in_valid) overflow_d = 1'b1;
            if (rd_ready) begin
                if (word_q == 2'd3) begin
                    word_d = 2'd0;
                    if (count_q == CW'(1)) begin
                        state_d    = S_IDLE;
                        rd_valid_d = 1'b0;
                        count_d    = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end else begin
                    word_d = word_q + 2'd1;
                end
            end
        end else if (arm) begin
            // arm beats any same-cycle retire, which is discarded.
            wr_ptr_d    = '0;
            count_d     = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
            mode_d      = mode;
            trig_pc_d   = trig_pc;
            post_cfg_d  = (post_count > MAX_POST) ? MAX_POST : post_count;
            state_d     = S_FILL;
        end else if (state_q == S_FILL || state_q == S_POST) begin
            if (in_valid) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                debug_d  = in_pc;
                // A full buffer overwrites its oldest record.
                if (count_q == FULL) overflow_d = 1'b1;
                else                 count_d    = count_q + CW'(1);

                if (state_q == S_POST) begin
                    post_d = post_q - CW'(1);
                    if (post_q == CW'(1)) state_d = S_DONE;
                end else if (!mode_q) begin
                    if (count_q == MAX_POST) state_d = S_DONE;
                end else if (in_pc == trig_pc_q) begin
                    triggered_d = 1'b1;
                    if (post_cfg_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        post_d  = post_cfg_q;
                        state_d = S_POST;
                    end
                end
            end
        end else if (state_q == S_DONE) begin
            if (in_valid) overflow_d = 1'b1;
            if (count_q != '0) begin
                state_d    = S_DRAIN;
                rd_valid_d = 1'b1;
                word_d     = 2'd0;
                rd_idx_d   = wr_ptr_q - count_q[AW-1:0];
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            post_cfg_q  <= '0;
            word_q      <= 2'd0;
            rd_valid_q  <= 1'b0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            mode_q      <= 1'b0;
            trig_pc_q   <= '0;
            debug_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_idx_q    <= rd_idx_d;
            count_q     <= count_d;
            post_q      <= post_d;
            post_cfg_q  <= post_cfg_d;
            word_q      <= word_d;
            rd_valid_q  <= rd_valid_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            mode_q      <= mode_d;
            trig_pc_q   <= trig_pc_d;
            debug_q     <= debug_d;
        end
    end

    // Record storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
            alu_mem_q[wr_ptr_q]   <= in_alu;
            wdata_mem_q[wr_ptr_q] <= in_wdata;
        end
    end

    // Asynchronous read of the current drain word.
    always_comb begin
        case (word_q)
            2'd0:    rd_data = pc_mem_q[rd_idx_q];
            2'd1:    rd_data = instr_mem_q[rd_idx_q];
            2'd2:    rd_data = alu_mem_q[rd_idx_q];
            default: rd_data = wdata_mem_q[rd_idx_q];
        endcase
    end

    assign rd_valid     = rd_valid_q;
    assign rd_word_idx  = word_q;
    assign rd_last      = rd_valid_q && (word_q == 2'd3) && (count_q == CW'(1));
    assign state        = state_q;
    assign count        = count_q;
    assign triggered    = triggered_q;
    assign overflow     = overflow_q;
    assign debug_output = debug_q;

endmodule

// File: tb/tb_rv_retire_trace_buffer.sv
// Testbench for rv_retire_trace_buffer: directed scenarios plus randomized
// capture rounds, checked every cycle against a record/word queue model.
module tb_rv_retire_trace_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam int ST_IDLE  = 0;
    localparam int ST_FILL  = 1;
    localparam int ST_POST  = 2;
    localparam int ST_DONE  = 3;
    localparam int ST_DRAIN = 4;

    logic            clk;
    logic            rst;
    logic            arm;
    logic            mode;
    logic [XLEN-1:0] trig_pc;
    logic [CW-1:0]   post_count;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_alu;
    logic [XLEN-1:0] in_wdata;
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_data;
    logic [1:0]      rd_word_idx;
    logic            rd_last;
    logic [2:0]      state;
    logic [CW-1:0]   count;
    logic            triggered;
    logic            overflow;
    logic [XLEN-1:0] debug_output;

    rv_retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .mode         (mode),
        .trig_pc      (trig_pc),
        .post_count   (post_count),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_alu       (in_alu),
        .in_wdata     (in_wdata),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_word_idx  (rd_word_idx),
        .rd_last      (rd_last),
        .state        (state),
        .count        (count),
        .triggered    (triggered),
        .overflow     (overflow),
        .debug_output (debug_output)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: captured records in a queue, drained as a word queue.
    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wdata;
    } rec_t;

    rec_t            m_q[$];
    logic [XLEN-1:0] exp_q[$];
    int              m_state;
    int              m_mode;
    logic [XLEN-1:0] m_trig;
    int              m_post;
    int              m_post_left;
    logic            m_triggered;
    logic            m_overflow;
    logic [XLEN-1:0] m_debug;

    int n_checks;
    int n_errors;

    // Observation of the drained stream (used by directed scenarios).
    logic [XLEN-1:0] drained_pc[$];
    int              n_beats;
    int              last_beat;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        exp_q.delete();
        m_state     = ST_IDLE;
        m_mode      = 0;
        m_trig      = '0;
        m_post      = 0;
        m_post_left = 0;
        m_triggered = 1'b0;
        m_overflow  = 1'b0;
        m_debug     = '0;
    endfunction

    function automatic int m_count();
        if (m_state == ST_DRAIN) return (exp_q.size() + 3) / 4;
        return m_q.size();
    endfunction

    // One clock of the specified behaviour, using the inputs driven this cycle.
    function automatic void model_step();
        rec_t r;
        if (m_state == ST_DRAIN) begin
            if (in_valid) m_overflow = 1'b1;
            if (rd_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_state = ST_IDLE;
            end
        end else if (arm) begin
            m_q.delete();
            m_triggered = 1'b0;
            m_overflow  = 1'b0;
            m_mode      = int'(mode);
            m_trig      = trig_pc;
            m_post      = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
            m_state     = ST_FILL;
        end else if (m_state == ST_FILL || m_state == ST_POST) begin
            if (in_valid) begin
                r.pc = in_pc; r.instr = in_instr; r.alu = in_alu; r.wdata = in_wdata;
                m_q.push_back(r);
                if (m_q.size() > DEPTH) begin
                    void'(m_q.pop_front());
                    m_overflow = 1'b1;
                end
                m_debug = in_pc;
                if (m_state == ST_POST) begin
                    m_post_left--;
                    if (m_post_left == 0) m_state = ST_DONE;
                end else if (m_mode == 0) begin
                    if (m_q.size() == DEPTH) m_state = ST_DONE;
                end else if (in_pc == m_trig) begin
                    m_triggered = 1'b1;
                    m_post_left = m_post;
                    m_state     = (m_post == 0) ? ST_DONE : ST_POST;
                end
            end
        end else if (m_state == ST_DONE) begin
            if (in_valid) m_overflow = 1'b1;
            if (m_q.size() > 0) begin
                foreach (m_q[i]) begin
                    exp_q.push_back(m_q[i].pc);
                    exp_q.push_back(m_q[i].instr);
                    exp_q.push_back(m_q[i].alu);
                    exp_q.push_back(m_q[i].wdata);
                end
                m_q.delete();
                m_state = ST_DRAIN;
            end else begin
                m_state = ST_IDLE;
            end
        end
    endfunction

    task automatic check_all();
        chk("state", XLEN'(state), XLEN'(m_state));
        chk("count", XLEN'(count), XLEN'(m_count()));
        chk("rd_valid", XLEN'(rd_valid), XLEN'(m_state == ST_DRAIN));
        chk("triggered", XLEN'(triggered), XLEN'(m_triggered));
        chk("overflow", XLEN'(overflow), XLEN'(m_overflow));
        chk("debug_output", debug_output, m_debug);
        if (m_state == ST_DRAIN) begin
            chk("rd_data", rd_data, exp_q[0]);
            chk("rd_word_idx", XLEN'(rd_word_idx), XLEN'((4 - (exp_q.size() % 4)) % 4));
            chk("rd_last", XLEN'(rd_last), XLEN'(exp_q.size() == 1));
        end else begin
            chk("rd_last_idle", XLEN'(rd_last), '0);
        end
    endtask

    // Driver: one full clock with the given inputs, then model update and checks.
    task automatic cycle(input logic a, input logic v, input logic [XLEN-1:0] pc, input logic rr);
        logic            stalled;
        logic [XLEN-1:0] stall_word;
        arm      = a;
        in_valid = v;
        in_pc    = pc;
        in_instr = $urandom;
        in_alu   = $urandom;
        in_wdata = $urandom;
        rd_ready = rr;
        stalled    = (m_state == ST_DRAIN) && !rr;
        stall_word = (m_state == ST_DRAIN) ? exp_q[0] : '0;
        if (rd_valid && rr) begin
            n_beats++;
            if (rd_word_idx == 2'd0) drained_pc.push_back(rd_data);
            if (rd_last) last_beat = n_beats;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        arm      = 1'b0;
        in_valid = 1'b0;
        check_all();
        if (stalled) chk("stall_hold", rd_data, stall_word);
    endtask

    task automatic do_arm(input logic md, input logic [XLEN-1:0] tpc, input logic [CW-1:0] pc_post);
        mode       = md;
        trig_pc    = tpc;
        post_count = pc_post;
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    // ready_style: 0 always ready, 1 toggle 1/0, 2 random
    task automatic run_drain(input int ready_style);
        int   budget;
        logic rr;
        budget = 600;
        rr     = 1'b1;
        drained_pc.delete();
        n_beats   = 0;
        last_beat = -1;
        while ((m_state == ST_DONE || m_state == ST_DRAIN) && budget > 0) begin
            if (ready_style == 0)      rr = 1'b1;
            else if (ready_style == 1) rr = ~rr;
            else                       rr = 1'($urandom_range(0, 1));
            cycle(1'b0, 1'b0, '0, rr);
            budget--;
        end
        n_checks++;
        assert (budget > 0) else begin
            n_errors++;
            $error("FAIL drain_timeout observed=%0d expected=%0d", m_state, ST_IDLE);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b0;
        arm        = 1'b0;
        mode       = 1'b0;
        trig_pc    = '0;
        post_count = '0;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_instr   = '0;
        in_alu     = '0;
        in_wdata   = '0;
        rd_ready   = 1'b0;
        n_beats    = 0;
        last_beat  = -1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        cycle(1'b0, 1'b0, '0, 1'b0);

        // T1: STOP mode fill to DONE and full drain
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, XLEN'(32'h100 + 4 * i), 1'b0);
        chk("t1_done", XLEN'(state), XLEN'(ST_DONE));
        run_drain(0);
        chk("t1_words", XLEN'(n_beats), XLEN'(4 * DEPTH));
        chk("t1_last_beat", XLEN'(last_beat), XLEN'(4 * DEPTH));
        chk("t1_first_pc", drained_pc[0], 32'h100);
        chk("t1_final_pc", drained_pc[DEPTH-1], 32'h13C);
        chk("t1_overflow", XLEN'(overflow), '0);

        // T2: retire during DONE is dropped and flags overflow
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, XLEN'(32'h400 + 4 * i), 1'b0);
        cycle(1'b0, 1'b1, 32'h0000_0DEAD, 1'b0);
        chk("t2_overflow", XLEN'(overflow), 1);
        run_drain(2);
        chk("t2_final_pc", drained_pc[DEPTH-1], 32'h43C);

        // T3: TRIG mode with wrap, post window of 3
        do_arm(1'b1, 32'h200, CW'(3));
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, XLEN'(32'h1000 + 4 * i), 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 1'b0);
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, XLEN'(32'h200 + 4 * i), 1'b0);
        chk("t3_triggered", XLEN'(triggered), 1);
        chk("t3_overflow", XLEN'(overflow), 1);
        chk("t3_count", XLEN'(count), XLEN'(DEPTH));
        run_drain(0);
        chk("t3_trigger_13th", drained_pc[12], 32'h200);
        chk("t3_last_pc", drained_pc[DEPTH-1], 32'h20C);

        // T4: backpressure with rd_ready toggling
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        run_drain(1);
        chk("t4_words", XLEN'(n_beats), XLEN'(4 * DEPTH));

        // T5: arm beats same-cycle retire; arm ignored in DRAIN
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        mode = 1'b0;
        cycle(1'b1, 1'b1, 32'h0BAD_0000, 1'b0);
        chk("t5_arm_clears", XLEN'(count), '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, XLEN'(32'h800 + 4 * i), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1);
        chk("t5_arm_ignored", XLEN'(state), XLEN'(ST_DRAIN));
        run_drain(0);
        chk("t5_drain_words", XLEN'(n_beats), XLEN'(4 * DEPTH - 1));

        // T6: asynchronous reset mid-drain, then normal re-arm
        do_arm(1'b0, '0, '0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_rd_valid", XLEN'(rd_valid), '0);
        chk("t6_state", XLEN'(state), XLEN'(ST_IDLE));
        chk("t6_count", XLEN'(count), '0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        check_all();
        do_arm(1'b1, 32'h77C, CW'(2));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, XLEN'(32'h770 + 4 * i), 1'b0);
        run_drain(0);
        chk("t6_rearm_records", XLEN'(drained_pc.size()), 6);

        // Randomized capture rounds
        for (int rnd = 0; rnd < 6; rnd++) begin
            do_arm(1'($urandom_range(0, 1)), XLEN'(32'h300 + 4 * $urandom_range(0, 15)),
                   CW'($urandom_range(0, 2 * DEPTH - 1)));
            for (int i = 0; i < 48; i++) begin
                cycle(1'b0, 1'($urandom_range(0, 3) != 0), XLEN'(32'h300 + 4 * $urandom_range(0, 15)), 1'b0);
            end
            run_drain(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
